vedic_multiplier_16x16: RTL and testbench

- Unsigned 16x16 -> 32-bit multiplier built on the Vedic Urdhva-Tiryagbhyam (vertical-and-crosswise) recursive decomposition.
- Combinational Vedic core with a registered product output.
- Used as a datapath arithmetic leaf; one clock domain.

---
 rtl/vedic_pkg.sv | 30 +++
 rtl/vedic_mul_nxn.sv | 43 ++++
 rtl/vedic_multiplier_16x16.sv | 60 ++++++
 tb/tb_vedic_multiplier_16x16.sv | 138 +++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Shared widths, types and final summation for the 16x16 Vedic multiplier.
// Build option: VEDIC_MULT_PIPE_EN adds a partial-product register stage.
package vedic_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;
  localparam int HALF_W = 8;

  typedef logic [OP_W-1:0]     op_t;
  typedef logic [PROD_W-1:0]   prod_t;
  typedef logic [2*HALF_W-1:0] pp_t;

  typedef struct packed {
    pp_t p3;
    pp_t p2;
    pp_t p1;
    pp_t p0;
  } pp_set_t;

  // P0 + ((P1+P2) << 8) + (P3 << 16); low byte of P0 needs no adder
  function automatic prod_t combine(input pp_set_t pp);
    logic [2*HALF_W:0]   mid;
    logic [3*HALF_W-1:0] upper;
    mid   = {1'b0, pp.p1} + {1'b0, pp.p2};
    upper = {pp.p3, pp.p0[2*HALF_W-1:HALF_W]}
          + {{(HALF_W-1){1'b0}}, mid};
    return {upper, pp.p0[HALF_W-1:0]};
  endfunction

endpackage

// File: rtl/vedic_mul_nxn.sv
// Recursive combinational NxN Urdhva-Tiryagbhyam multiplier.
// N == 2 is the AND/half-adder leaf; larger N splits into four N/2 units.
module vedic_mul_nxn #(
  parameter int N = 8
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  if (N == 2) begin : g_leaf
    logic cross_s;
    logic cross_c;
    logic top;
    assign top     = a[1] & b[1];
    assign cross_s = (a[1] & b[0]) ^ (a[0] & b[1]);
    assign cross_c = (a[1] & b[0]) & (a[0] & b[1]);
    assign p[0]    = a[0] & b[0];
    assign p[1]    = cross_s;
    assign p[2]    = top ^ cross_c;
    assign p[3]    = top & cross_c;
  end else begin : g_split
    localparam int H = N / 2;
    localparam int U = N + H;

    logic [N-1:0] q0;
    logic [N-1:0] q1;
    logic [N-1:0] q2;
    logic [N-1:0] q3;
    logic [N:0]   mid;
    logic [U-1:0] upper;

    vedic_mul_nxn #(.N(H)) u_q0 (.a(a[H-1:0]), .b(b[H-1:0]), .p(q0));
    vedic_mul_nxn #(.N(H)) u_q1 (.a(a[N-1:H]), .b(b[H-1:0]), .p(q1));
    vedic_mul_nxn #(.N(H)) u_q2 (.a(a[H-1:0]), .b(b[N-1:H]), .p(q2));
    vedic_mul_nxn #(.N(H)) u_q3 (.a(a[N-1:H]), .b(b[N-1:H]), .p(q3));

    assign mid   = {1'b0, q1} + {1'b0, q2};
    assign upper = {q3, q0[N-1:H]} + {{(H-1){1'b0}}, mid};
    assign p     = {upper, q0[H-1:0]};
  end

endmodule

// File: rtl/vedic_multiplier_16x16.sv
// Registered 16x16 unsigned Vedic multiplier built from four 8x8 units.
// Build option: VEDIC_MULT_PIPE_EN registers the partials (latency 2).
module vedic_multiplier_16x16
  import vedic_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] multiplicand,
  input  logic [15:0] multiplier,
  output logic [31:0] product
);

  op_t     a;
  op_t     b;
  pp_t     p0;
  pp_t     p1;
  pp_t     p2;
  pp_t     p3;
  pp_set_t pp_c;
  pp_set_t pp_sum;

  assign a = multiplicand;
  assign b = multiplier;

  vedic_mul_nxn #(.N(HALF_W)) u_p0 (
    .a(a[HALF_W-1:0]), .b(b[HALF_W-1:0]), .p(p0)
  );
  vedic_mul_nxn #(.N(HALF_W)) u_p1 (
    .a(a[OP_W-1:HALF_W]), .b(b[HALF_W-1:0]), .p(p1)
  );
  vedic_mul_nxn #(.N(HALF_W)) u_p2 (
    .a(a[HALF_W-1:0]), .b(b[OP_W-1:HALF_W]), .p(p2)
  );
  vedic_mul_nxn #(.N(HALF_W)) u_p3 (
    .a(a[OP_W-1:HALF_W]), .b(b[OP_W-1:HALF_W]), .p(p3)
  );

  assign pp_c = '{p3: p3, p2: p2, p1: p1, p0: p0};

`ifdef VEDIC_MULT_PIPE_EN
  pp_set_t pp_q;

  // Hold the four partial products ahead of the final adders
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pp_q <= '0;
    else     pp_q <= pp_c;
  end

  assign pp_sum = pp_q;
`else
  assign pp_sum = pp_c;
`endif

  // Final summation into the output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) product <= '0;
    else     product <= combine(pp_sum);
  end

endmodule

// File: tb/tb_vedic_multiplier_16x16.sv
// Directed and random checks for vedic_multiplier_16x16.
// Honours VEDIC_MULT_PIPE_EN for the expected latency.
module tb_vedic_multiplier_16x16;

`ifdef VEDIC_MULT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic [31:0] product;

  int n_run;
  int n_fail;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[8];

  vedic_multiplier_16x16 dut (
    .clk(clk),
    .rst(rst),
    .multiplicand(multiplicand),
    .multiplier(multiplier),
    .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] exp);
    n_run++;
    if (product !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, product, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] s_exp[3];
  logic [15:0] s_a[3];
  logic [15:0] s_b[3];
  logic [31:0] hist[$];

  initial begin
    n_run  = 0;
    n_fail = 0;

    vecs[0] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "max"};
    vecs[1] = '{16'h0000, 16'hABCD, 32'h0000_0000, "zero_a"};
    vecs[2] = '{16'hABCD, 16'h0000, 32'h0000_0000, "zero_b"};
    vecs[3] = '{16'h0001, 16'hBEEF, 32'h0000_BEEF, "one_a"};
    vecs[4] = '{16'hBEEF, 16'h0001, 32'h0000_BEEF, "one_b"};
    vecs[5] = '{16'h8000, 16'h0002, 32'h0001_0000, "shift"};
    vecs[6] = '{16'h00FF, 16'hFF00, 32'h00FE_0100, "bytes"};
    vecs[7] = '{16'h1234, 16'h5678, 32'h0626_0060, "mixed"};

    // reset held two cycles with live operands
    rst = 1'b1;
    multiplicand = 16'h1234;
    multiplier   = 16'h5678;
    #2;
    check("rst_t0", 32'h0);
    tick();
    check("rst_c1", 32'h0);
    tick();
    check("rst_c2", 32'h0);
    rst = 1'b0;
    repeat (LAT) tick();
    check("rst_release", 32'h0626_0060);

    // directed table
    for (int i = 0; i < 8; i++) begin
      multiplicand = vecs[i].a;
      multiplier   = vecs[i].b;
      repeat (LAT) tick();
      check(vecs[i].name, vecs[i].exp);
    end

    // back-to-back stream, no bubbles
    s_a[0] = 16'h1234; s_b[0] = 16'h5678; s_exp[0] = 32'h0626_0060;
    s_a[1] = 16'h00FF; s_b[1] = 16'hFF00; s_exp[1] = 32'h00FE_0100;
    s_a[2] = 16'hFFFF; s_b[2] = 16'h0001; s_exp[2] = 32'h0000_FFFF;
    for (int k = 0; k < 3 + LAT; k++) begin
      if (k >= LAT) check("stream", s_exp[k-LAT]);
      if (k < 3) begin
        multiplicand = s_a[k];
        multiplier   = s_b[k];
      end
      tick();
    end

    // async reset pulse between edges
    multiplicand = 16'hFFFF;
    multiplier   = 16'hFFFF;
    repeat (LAT) tick();
    check("pre_pulse", 32'hFFFE_0001);
    multiplicand = 16'h1234;
    multiplier   = 16'h5678;
    #2;
    rst = 1'b1;
    #1;
    check("async_clear", 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check("async_hold", 32'h0);
    repeat (LAT) tick();
    check("resume", 32'h0626_0060);

    // random stream against the golden product
    hist.delete();
    for (int k = 0; k < 10000 + LAT; k++) begin
      if (k >= LAT) check("random", hist.pop_front());
      multiplicand = 16'($urandom);
      multiplier   = 16'($urandom);
      hist.push_back(32'(multiplicand) * 32'(multiplier));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
